// File: rtl/alu_bitserial_seq.sv
// Bit-serial sequencer for a 1-bit ALU slice: drives bit idx per clock, LSB first, and assembles the result.
// Latency: done WIDTH cycles after accept (WIDTH+1 for slt); result/flags registered on the edge entering DONE.
// Backpressure: ready only in IDLE; start while busy (RUN/FIX/DONE) is ignored, nothing is queued.
module alu_bitserial_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       alu_ctl,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             overflow,
    output logic             illegal,
    output logic             sl_a,
    output logic             sl_b,
    output logic             sl_less,
    output logic             sl_ainvert,
    output logic             sl_binvert,
    output logic             sl_carryin,
    output logic [1:0]       sl_operation,
    input  logic             sl_result,
    input  logic             sl_carryout,
    input  logic             sl_set,
    input  logic             sl_overflow
);

    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IW-1:0] LAST = IW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  a_q, b_q;
    logic [3:0]        ctl_q;
    logic [IW-1:0]     idx_q, idx_d;
    logic              carry_q, carry_d;
    logic [WIDTH-1:0]  r_q, r_d;
    logic              set_q, set_d;
    logic [WIDTH-1:0]  result_q;
    logic              zero_q, overflow_q, illegal_q;
    logic              ovf_d;
    logic              legal, is_slt, is_arith;
    logic              accept, fin_load;

    assign legal    = ctl_q inside {4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100};
    assign is_slt   = (ctl_q == 4'b0111);
    assign is_arith = (ctl_q == 4'b0010) || (ctl_q == 4'b0110);
    assign accept   = (state_q == IDLE) && start;

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        carry_d      = carry_q;
        r_d          = r_q;
        set_d        = set_q;
        ovf_d        = 1'b0;
        sl_a         = 1'b0;
        sl_b         = 1'b0;
        sl_less      = 1'b0;
        sl_ainvert   = 1'b0;
        sl_binvert   = 1'b0;
        sl_carryin   = 1'b0;
        sl_operation = 2'b00;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    idx_d   = '0;
                    carry_d = 1'b0;
                    r_d     = '0;
                    set_d   = 1'b0;
                end
            end
            RUN: begin
                // Illegal opcodes still take the full WIDTH cycles, with the slice held quiet.
                if (legal) begin
                    sl_a         = a_q[idx_q];
                    sl_b         = b_q[idx_q];
                    sl_ainvert   = ctl_q[3];
                    sl_binvert   = ctl_q[2];
                    sl_operation = ctl_q[1:0];
                    sl_carryin   = (idx_q == '0) ? ctl_q[2] : carry_q;
                end
                r_d[idx_q] = legal & sl_result;
                carry_d    = legal & sl_carryout;
                idx_d      = idx_q + IW'(1);
                if (idx_q == LAST) begin
                    set_d   = legal & sl_set;
                    ovf_d   = legal & is_arith & sl_overflow;
                    state_d = is_slt ? FIX : DONE;
                end
            end
            FIX: begin
                // Second pass over bit 0 routes the captured sign of A-B through the Less input.
                sl_a         = a_q[0];
                sl_b         = b_q[0];
                sl_ainvert   = ctl_q[3];
                sl_binvert   = ctl_q[2];
                sl_operation = 2'b11;
                sl_less      = set_q;
                sl_carryin   = 1'b1;
                r_d[0]       = sl_result;
                state_d      = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign fin_load = (state_q != DONE) && (state_d == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            a_q        <= '0;
            b_q        <= '0;
            ctl_q      <= '0;
            idx_q      <= '0;
            carry_q    <= 1'b0;
            r_q        <= '0;
            set_q      <= 1'b0;
            result_q   <= '0;
            zero_q     <= 1'b0;
            overflow_q <= 1'b0;
            illegal_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            r_q     <= r_d;
            set_q   <= set_d;
            if (accept) begin
                a_q   <= op_a;
                b_q   <= op_b;
                ctl_q <= alu_ctl;
            end
            if (fin_load) begin
                result_q   <= r_d;
                zero_q     <= (r_d == '0);
                overflow_q <= ovf_d;
                illegal_q  <= ~legal;
            end
        end
    end

    assign ready    = (state_q == IDLE);
    assign busy     = ~ready;
    assign done     = (state_q == DONE);
    assign result   = result_q;
    assign zero     = zero_q;
    assign overflow = overflow_q;
    assign illegal  = illegal_q;

endmodule

// File: tb/tb_alu_bitserial_seq.sv
// Bench for alu_bitserial_seq with a behavioural 1-bit slice and a scoreboard of expected results.
module tb_alu_bitserial_seq;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [3:0]    alu_ctl = '0;
    logic [W-1:0]  op_a = '0, op_b = '0;
    logic          ready, busy, done, zero, overflow, illegal;
    logic [W-1:0]  result;
    logic          sl_a, sl_b, sl_less, sl_ainvert, sl_binvert, sl_carryin;
    logic [1:0]    sl_operation;
    logic          sl_result, sl_carryout, sl_set, sl_overflow;

    alu_bitserial_seq #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .alu_ctl(alu_ctl),
        .op_a(op_a), .op_b(op_b), .ready(ready), .busy(busy), .done(done),
        .result(result), .zero(zero), .overflow(overflow), .illegal(illegal),
        .sl_a(sl_a), .sl_b(sl_b), .sl_less(sl_less), .sl_ainvert(sl_ainvert),
        .sl_binvert(sl_binvert), .sl_carryin(sl_carryin), .sl_operation(sl_operation),
        .sl_result(sl_result), .sl_carryout(sl_carryout), .sl_set(sl_set),
        .sl_overflow(sl_overflow)
    );

    always #5 clk = ~clk;

    // Textbook 1-bit ALU slice, MSB flavour.
    logic a2, b2, s;
    always_comb begin
        a2          = sl_a ^ sl_ainvert;
        b2          = sl_b ^ sl_binvert;
        s           = a2 ^ b2 ^ sl_carryin;
        sl_carryout = (a2 & b2) | (a2 & sl_carryin) | (b2 & sl_carryin);
        sl_set      = s;
        sl_overflow = sl_carryin ^ sl_carryout;
        case (sl_operation)
            2'b00:   sl_result = a2 & b2;
            2'b01:   sl_result = a2 | b2;
            2'b10:   sl_result = s;
            default: sl_result = sl_less;
        endcase
    end

    typedef struct {
        logic [W-1:0] res;
        logic         zero;
        logic         ovf;
        logic         ill;
        int           lat;
        int           acc;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   done_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [3:0] ctl, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        logic [W-1:0] d;
        e.res = '0; e.ovf = 1'b0; e.ill = 1'b0; e.lat = W; e.acc = 0;
        case (ctl)
            4'b0000: e.res = a & b;
            4'b0001: e.res = a | b;
            4'b0010: begin
                e.res = a + b;
                e.ovf = (a[W-1] == b[W-1]) && (e.res[W-1] != a[W-1]);
            end
            4'b0110: begin
                e.res = a - b;
                e.ovf = (a[W-1] != b[W-1]) && (e.res[W-1] != a[W-1]);
            end
            4'b0111: begin
                d = a - b;
                e.res = {{(W-1){1'b0}}, d[W-1]};
                e.lat = W + 1;
            end
            4'b1100: e.res = ~(a | b);
            default: e.ill = 1'b1;
        endcase
        e.zero = (e.res == '0);
        return e;
    endfunction

    always @(negedge clk) begin
        if (done) begin
            exp_t e;
            done_cnt++;
            if (sb.size() == 0) begin
                check("unexpected_done", 32'(done), 32'd0);
            end else begin
                e = sb.pop_front();
                check("result", result, e.res);
                check("zero", 32'(zero), 32'(e.zero));
                check("overflow", 32'(overflow), 32'(e.ovf));
                check("illegal", 32'(illegal), 32'(e.ill));
                check("latency", 32'(cyc - e.acc), 32'(e.lat));
                check("ready_in_done", 32'(ready), 32'd0);
            end
        end
    end

    task automatic issue(input logic [3:0] ctl, input logic [W-1:0] a, input logic [W-1:0] b,
                         input bit push);
        exp_t e;
        int   n;
        @(negedge clk);
        n = 0;
        while (!ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!ready) check("ready_timeout", 32'(ready), 32'd1);
        start = 1'b1; alu_ctl = ctl; op_a = a; op_b = b;
        @(posedge clk);
        #1;
        start = 1'b0;
        op_a = $urandom; op_b = $urandom; alu_ctl = 4'($urandom);
        if (push) begin
            e = model(ctl, a, b);
            e.acc = cyc;
            sb.push_back(e);
        end
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 200 && sb.size() != 0; i++) @(posedge clk);
        check("drain_timeout", 32'(sb.size()), 32'd0);
        repeat (3) @(posedge clk);
    endtask

    function automatic logic [W-1:0] sl_bus();
        return {{(W-8){1'b0}}, sl_a, sl_b, sl_less, sl_ainvert, sl_binvert, sl_carryin, sl_operation};
    endfunction

    initial begin
        int d0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_flags", {29'd0, zero, overflow, illegal}, 32'd0);
        check("rst_sl", sl_bus(), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        issue(4'b0010, 32'h5, 32'h3, 1'b1);           wait_idle();
        issue(4'b0110, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b1); wait_idle();
        issue(4'b0010, 32'hFFFF_FFFF, 32'h1, 1'b1);   wait_idle();
        issue(4'b0111, 32'hFFFF_FFFE, 32'h1, 1'b1);   wait_idle();
        issue(4'b0111, 32'h1, 32'hFFFF_FFFE, 1'b1);   wait_idle();
        issue(4'b0000, 32'h0F0F, 32'h00FF, 1'b1);     wait_idle();
        issue(4'b0001, 32'h0F0F, 32'h00FF, 1'b1);     wait_idle();
        issue(4'b1100, 32'h0, 32'h0, 1'b1);           wait_idle();
        check("idle_sl", sl_bus(), 32'd0);

        issue(4'b0101, 32'hDEAD_BEEF, 32'h1234_5678, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        check("illegal_sl_quiet", sl_bus(), 32'd0);
        wait_idle();

        // A second start mid-op must be dropped without disturbing the first.
        d0 = done_cnt;
        issue(4'b0010, 32'h1000, 32'h0234, 1'b1);
        repeat (5) @(posedge clk);
        @(negedge clk);
        start = 1'b1; alu_ctl = 4'b0001; op_a = 32'hFFFF_0000; op_b = 32'h0000_FFFF;
        @(negedge clk);
        start = 1'b0;
        wait_idle();
        repeat (40) @(posedge clk);
        check("single_done", 32'(done_cnt - d0), 32'd1);

        // Abort mid-flight, then confirm the next op is clean.
        d0 = done_cnt;
        issue(4'b0110, 32'h100, 32'h1, 1'b0);
        repeat (9) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_ready", 32'(ready), 32'd1);
        check("abort_result", result, 32'd0);
        check("abort_done", 32'(done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(posedge clk);
        check("abort_no_done", 32'(done_cnt - d0), 32'd0);
        issue(4'b0010, 32'h7FFF_FFFF, 32'h1, 1'b1);   wait_idle();

        for (int i = 0; i < 8; i++) begin
            logic [3:0] c;
            case ($urandom_range(0, 5))
                0: c = 4'b0000; 1: c = 4'b0001; 2: c = 4'b0010;
                3: c = 4'b0110; 4: c = 4'b0111; default: c = 4'b1100;
            endcase
            issue(c, $urandom, $urandom, 1'b1);
            wait_idle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
